// File: rtl/aes_pkg.sv
// Shared AES constants, the key-schedule state type and the round-constant table.
package aes_pkg;

  localparam int unsigned NR       = 10;
  localparam int unsigned NK       = 4;
  localparam int unsigned RkW      = 128;
  localparam int unsigned FullKeyW = RkW * (NR + 1);

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StHold,
    StStream
  } ks_state_e;

  // Rcon table indexed by the round being produced (1..10); other indices return 0.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] v;
    case (round)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Key-load handshake, round-key bus and round-key stream of the key schedule.
interface aes_key_schedule_seq_if;
  import aes_pkg::*;

  logic [RkW-1:0]      key_in;
  logic                key_valid;
  logic                key_ready;
  logic                keys_valid;
  logic [FullKeyW-1:0] full_key;
  logic                stream_start;
  logic                rk_valid;
  logic                rk_ready;
  logic [RkW-1:0]      rk_data;
  logic [3:0]          rk_round;
  logic                rk_last;

  modport master (
    output key_in, key_valid, stream_start, rk_ready,
    input  key_ready, keys_valid, full_key, rk_valid, rk_data, rk_round, rk_last
  );

  modport slave (
    input  key_in, key_valid, stream_start, rk_ready,
    output key_ready, keys_valid, full_key, rk_valid, rk_data, rk_round, rk_last
  );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte lookup.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 occupies the most significant byte.
  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_base;

  // Bit offset of entry i is 8*(255-i).
  assign w_base = {~i_byte, 3'b000};
  assign o_byte = SboxTab[w_base +: 8];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key schedule: one round key per clock into a register file, exposed as a
// flat bus and as a replayable round 10..0 stream. Optional build macro AES_KEYSCHED_CACHE_EN
// skips re-expansion when the key reloaded in HOLD matches the stored cipher key.
module aes_key_schedule_seq #(
  parameter int unsigned NR = 10
) (
  input logic                   clk,
  input logic                   rst,
  aes_key_schedule_seq_if.slave bus
);
  import aes_pkg::*;

  ks_state_e        r_state, w_state_d;
  logic [RkW-1:0]   r_rk [NR+1];
  logic [3:0]       r_cnt;
  logic [3:0]       r_idx;
  logic [RkW-1:0]   r_rk_data;
  logic [3:0]       r_rk_round;

  logic             w_key_fire, w_cache_hit, w_reload, w_start, w_rk_fire;
  logic [RkW-1:0]   w_prev, w_next, w_rk_prev_idx;
  logic [31:0]      w_w0, w_w1, w_w2, w_w3, w_rot, w_sub, w_temp;
  logic [31:0]      w_n0, w_n1, w_n2, w_n3;

  assign w_key_fire = bus.key_valid & bus.key_ready;
`ifdef AES_KEYSCHED_CACHE_EN
  assign w_cache_hit = (r_state == StHold) && (bus.key_in == r_rk[0]);
`else
  assign w_cache_hit = 1'b0;
`endif
  assign w_reload  = w_key_fire & ~w_cache_hit;
  // A simultaneous key offer takes priority over starting the stream.
  assign w_start   = (r_state == StHold) & bus.stream_start & ~bus.key_valid;
  assign w_rk_fire = (r_state == StStream) & bus.rk_ready;

  // Select the previous round key (rk[cnt-1]) and the next stream key (rk[idx-1]).
  always_comb begin
    w_prev        = '0;
    w_rk_prev_idx = '0;
    for (int i = 0; i < NR; i++) begin
      if (r_cnt == 4'(i + 1)) w_prev = r_rk[i];
      if (r_idx == 4'(i + 1)) w_rk_prev_idx = r_rk[i];
    end
  end

  assign {w_w0, w_w1, w_w2, w_w3} = w_prev;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < NK; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_temp = w_sub ^ {rcon(r_cnt), 24'h0};
  assign w_n0   = w_w0 ^ w_temp;
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next-state decode.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_key_fire) w_state_d = StExpand;
      StExpand: if (r_cnt == 4'(NR)) w_state_d = StHold;
      StHold: begin
        if (w_reload)     w_state_d = StExpand;
        else if (w_start) w_state_d = StStream;
      end
      StStream: if (w_rk_fire && (r_idx == 4'd0)) w_state_d = StHold;
      default:  w_state_d = StIdle;
    endcase
  end

  // Round-key register file, expansion counter and stream registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rk_data  <= '0;
      r_rk_round <= '0;
    end else begin
      if (w_reload) begin
        r_rk[0] <= bus.key_in;
        r_cnt   <= 4'd1;
      end else if (r_state == StExpand) begin
        for (int i = 1; i <= NR; i++) begin
          if (r_cnt == 4'(i)) r_rk[i] <= w_next;
        end
        r_cnt <= r_cnt + 4'd1;
      end

      if (w_start) begin
        r_idx      <= 4'(NR);
        r_rk_data  <= r_rk[NR];
        r_rk_round <= 4'(NR);
      end else if (w_rk_fire && (r_idx != 4'd0)) begin
        r_idx      <= r_idx - 4'd1;
        r_rk_data  <= w_rk_prev_idx;
        r_rk_round <= r_idx - 4'd1;
      end
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_full_key
    assign bus.full_key[FullKeyW-1-RkW*g -: RkW] = r_rk[g];
  end

  assign bus.key_ready  = (r_state == StIdle) || (r_state == StHold);
  assign bus.keys_valid = (r_state == StHold) || (r_state == StStream);
  assign bus.rk_valid   = (r_state == StStream);
  assign bus.rk_last    = (r_state == StStream) && (r_idx == 4'd0);
  assign bus.rk_data    = r_rk_data;
  assign bus.rk_round   = r_rk_round;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench for aes_key_schedule_seq using FIPS-197 and all-zero/all-one key vectors.
module tb_aes_key_schedule_seq;
  import aes_pkg::*;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   rnd;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  beat_t        sb_q[$];
  logic [127:0] fips_rk [11];
  logic         stall_seen = 1'b0;
  logic [127:0] stall_data;
  logic [3:0]   stall_rnd;

  aes_key_schedule_seq_if bus ();

  aes_key_schedule_seq #(.NR(10)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Stream monitor: pop the scoreboard on each handshake, check stall stability.
  always @(negedge clk) begin
    if (!rst && bus.rk_valid) begin
      if (stall_seen) begin
        check_eq("stall_data_stable", bus.rk_data, stall_data);
        check_eq("stall_round_stable", 128'(bus.rk_round), 128'(stall_rnd));
      end
      if (bus.rk_ready) begin
        stall_seen = 1'b0;
        if (sb_q.size() == 0) begin
          check_eq("unexpected_beat", 128'(bus.rk_valid), 128'(0));
        end else begin
          beat_t b;
          b = sb_q.pop_front();
          check_eq("rk_data", bus.rk_data, b.data);
          check_eq("rk_round", 128'(bus.rk_round), 128'(b.rnd));
          check_eq("rk_last", 128'(bus.rk_last), 128'(b.rnd == 4'd0));
        end
      end else begin
        stall_seen = 1'b1;
        stall_data = bus.rk_data;
        stall_rnd  = bus.rk_round;
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  task automatic send_key(input logic [127:0] k);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1 bus.key_valid = 1'b0;
  endtask

  task automatic wait_keys(output int cycles);
    cycles = 0;
    while (!bus.keys_valid && cycles < 40) begin
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic run_stream(input bit random_ready);
    int n;
    for (int r = 10; r >= 0; r--) sb_q.push_back('{fips_rk[r], 4'(r)});
    bus.rk_ready     = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.stream_start = 1'b1;
    @(posedge clk);
    #1 bus.stream_start = 1'b0;
    check_eq("rk_valid_after_start", 128'(bus.rk_valid), 128'(1));
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      if (random_ready) bus.rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 n++;
    end
    check_eq("stream_drained", 128'(sb_q.size()), 128'(0));
    if (!random_ready) check_eq("stream_cycles", 128'(n), 128'(11));
    check_eq("rk_valid_after_stream", 128'(bus.rk_valid), 128'(0));
    check_eq("hold_key_ready", 128'(bus.key_ready), 128'(1));
    check_eq("hold_keys_valid", 128'(bus.keys_valid), 128'(1));
    bus.rk_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int low;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    bus.key_in       = '0;
    bus.key_valid    = 1'b0;
    bus.stream_start = 1'b0;
    bus.rk_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset values.
    check_eq("rst_key_ready", 128'(bus.key_ready), 128'(1));
    check_eq("rst_keys_valid", 128'(bus.keys_valid), 128'(0));
    check_eq("rst_full_key_top", bus.full_key[1407:1280], 128'(0));
    check_eq("rst_full_key_bot", bus.full_key[127:0], 128'(0));
    check_eq("rst_rk_valid", 128'(bus.rk_valid), 128'(0));
    check_eq("rst_rk_data", bus.rk_data, 128'(0));
    check_eq("rst_rk_round", 128'(bus.rk_round), 128'(0));
    check_eq("rst_rk_last", 128'(bus.rk_last), 128'(0));
    rst = 1'b0;
    @(posedge clk);

    // stream_start in IDLE is ignored.
    #1 bus.stream_start = 1'b1;
    @(posedge clk);
    #1 bus.stream_start = 1'b0;
    check_eq("idle_start_ignored", 128'(bus.rk_valid), 128'(0));
    check_eq("idle_key_ready", 128'(bus.key_ready), 128'(1));

    // FIPS-197 key; stream_start during EXPAND is ignored.
    send_key(fips_rk[0]);
    check_eq("expand_key_ready", 128'(bus.key_ready), 128'(0));
    bus.stream_start = 1'b1;
    @(posedge clk);
    #1 bus.stream_start = 1'b0;
    check_eq("expand_start_ignored", 128'(bus.rk_valid), 128'(0));
    wait_keys(cyc);
    check_eq("fips_latency", 128'(cyc + 1), 128'(10));
    for (int r = 0; r <= 10; r++) check_eq("fips_full_key", bus.full_key[1407-128*r -: 128],
                                           fips_rk[r]);

    run_stream(1'b0);
    check_eq("rk_data_held", bus.rk_data, fips_rk[0]);
    check_eq("rk_round_held", 128'(bus.rk_round), 128'(0));
    run_stream(1'b1);

    // Zero key, then all-ones key on the first HOLD cycle.
    send_key(128'h0);
    wait_keys(cyc);
    check_eq("zero_latency", 128'(cyc), 128'(10));
    check_eq("zero_round1", bus.full_key[1279:1152], 128'h62636363626363636263636362636363);
    check_eq("zero_round10", bus.full_key[127:0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check_eq("b2b_key_ready", 128'(bus.key_ready), 128'(1));
    send_key({128{1'b1}});
    check_eq("b2b_keys_valid_drop", 128'(bus.keys_valid), 128'(0));
    wait_keys(cyc);
    check_eq("ones_latency", 128'(cyc), 128'(10));
    check_eq("ones_round0", bus.full_key[1407:1280], {128{1'b1}});
    check_eq("ones_round1", bus.full_key[1279:1152], 128'he8e9e9e917161616e8e9e9e917161616);

    // key_valid and stream_start together in HOLD: key wins.
    bus.key_in       = fips_rk[0];
    bus.key_valid    = 1'b1;
    bus.stream_start = 1'b1;
    @(posedge clk);
    #1 bus.key_valid = 1'b0;
    bus.stream_start = 1'b0;
    check_eq("both_no_stream", 128'(bus.rk_valid), 128'(0));
    check_eq("both_expanding", 128'(bus.keys_valid), 128'(0));
    check_eq("both_key_ready", 128'(bus.key_ready), 128'(0));

    // Asynchronous reset in EXPAND cycle 5.
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_key_ready", 128'(bus.key_ready), 128'(1));
    check_eq("mid_rst_keys_valid", 128'(bus.keys_valid), 128'(0));
    check_eq("mid_rst_full_key_top", bus.full_key[1407:1280], 128'(0));
    check_eq("mid_rst_full_key_r1", bus.full_key[1279:1152], 128'(0));
    check_eq("mid_rst_rk_data", bus.rk_data, 128'(0));
    check_eq("mid_rst_rk_round", 128'(bus.rk_round), 128'(0));
    check_eq("mid_rst_rk_valid", 128'(bus.rk_valid), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reload the same key in HOLD.
    send_key(fips_rk[0]);
    wait_keys(cyc);
    check_eq("reload_base_latency", 128'(cyc), 128'(10));
    check_eq("reload_key_ready", 128'(bus.key_ready), 128'(1));
    send_key(fips_rk[0]);
    low = 0;
    for (int i = 0; i < 14; i++) begin
      if (!bus.keys_valid) low++;
      @(posedge clk);
      #1;
    end
`ifdef AES_KEYSCHED_CACHE_EN
    check_eq("reload_low_cycles", 128'(low), 128'(0));
`else
    check_eq("reload_low_cycles", 128'(low), 128'(10));
`endif
    check_eq("reload_keys_valid", 128'(bus.keys_valid), 128'(1));
    check_eq("reload_round10", bus.full_key[127:0], fips_rk[10]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
